// File: rtl/alu_arbiter.sv
// Shares one registered ALU among NREQ requesters: one operation at a time, tagged response.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         i_req_valid,
  output logic [NREQ-1:0]         o_req_ready,
  input  logic [NREQ*WIDTH-1:0]   i_req_a,
  input  logic [NREQ*WIDTH-1:0]   i_req_b,
  input  logic [NREQ*5-1:0]       i_req_op,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [IDW-1:0]          o_rsp_id,
  output logic [WIDTH-1:0]        o_rsp_data,
  output logic [2:0]              o_rsp_flags,
  output logic                    o_rsp_err,
  output logic                    o_alu_en,
  output logic [WIDTH-1:0]        o_alu_a,
  output logic [WIDTH-1:0]        o_alu_b,
  output logic [4:0]              o_alu_op,
  input  logic [WIDTH-1:0]        i_alu_data_out,
  input  logic                    i_alu_valid,
  input  logic                    i_alu_z,
  input  logic                    i_alu_g,
  input  logic                    i_alu_l
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_any;
  logic [IDW-1:0]   w_gnt_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [4:0]       r_op;
  logic [IDW-1:0]   r_id;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_inc;
  logic             w_timeout;
  logic             r_alu_en;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic [2:0]       r_rsp_flags;
  logic             r_rsp_err;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest-index valid requester wins.
  always_comb begin
    w_any    = 1'b0;
    w_gnt_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_gnt_id = (i_req_valid[IDW'(i)] && !w_any) ? IDW'(i) : w_gnt_id;
      w_any    = w_any | i_req_valid[IDW'(i)];
    end
  end
`else
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] w_idx;

  // Round-robin: search starts one past the last winner, wrapping at NREQ.
  always_comb begin
    w_any    = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx    = IDW'((int'(r_rr_ptr) + k) % NREQ);
      w_gnt_id = (i_req_valid[w_idx] && !w_any) ? w_idx : w_gnt_id;
      w_any    = w_any | i_req_valid[w_idx];
    end
  end

  // Round-robin pointer remembers the last granted requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= IDW'(NREQ - 1);
    end else if (r_state == S_IDLE && w_any) begin
      r_rr_ptr <= w_gnt_id;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end
`endif

  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_timeout = (w_cnt_inc == 8'(TIMEOUT));

  // Grant pulse is the same-cycle handshake with the winning requester; held low during reset.
  always_comb begin
    o_req_ready = '0;
    if (r_state == S_IDLE && w_any && !rst) begin
      o_req_ready[w_gnt_id] = 1'b1;
    end else begin
      o_req_ready = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_next = S_ISSUE;
        else       w_state_next = S_IDLE;
      end
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT: begin
        if (i_alu_valid || w_timeout) w_state_next = S_RESP;
        else                          w_state_next = S_WAIT;
      end
      S_RESP: begin
        if (i_rsp_ready) w_state_next = S_IDLE;
        else             w_state_next = S_RESP;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand latch, ALU enable pulse, timeout counter and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 5'd0;
      r_id        <= '0;
      r_cnt       <= 8'd0;
      r_alu_en    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_flags <= 3'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_alu_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a      <= i_req_a[w_gnt_id*WIDTH +: WIDTH];
            r_b      <= i_req_b[w_gnt_id*WIDTH +: WIDTH];
            r_op     <= i_req_op[w_gnt_id*5 +: 5];
            r_id     <= w_gnt_id;
            r_alu_en <= 1'b1;
          end
        end
        S_ISSUE: r_cnt <= 8'd0;
        S_WAIT: begin
          if (i_alu_valid) begin
            r_rsp_data  <= i_alu_data_out;
            r_rsp_flags <= {i_alu_z, i_alu_g, i_alu_l};
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
          end else if (w_timeout) begin
            r_rsp_data  <= '0;
            r_rsp_flags <= 3'd0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: r_alu_en <= 1'b0;
      endcase
    end
  end

  assign o_alu_en    = r_alu_en;
  assign o_alu_a     = r_a;
  assign o_alu_b     = r_b;
  assign o_alu_op    = r_op;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_id;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_flags = r_rsp_flags;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a registered ALU model.
module tb_alu_arbiter;
  localparam int WIDTH   = 32;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 15;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*5-1:0]     req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic [2:0]            rsp_flags;
  logic                  rsp_err;
  logic                  alu_en;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [4:0]            alu_op;
  logic [WIDTH-1:0]      alu_data;
  logic                  alu_valid;
  logic                  alu_z, alu_g, alu_l;
  logic                  stall;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_op(req_op),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_data(rsp_data), .o_rsp_flags(rsp_flags), .o_rsp_err(rsp_err),
    .o_alu_en(alu_en), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_data_out(alu_data), .i_alu_valid(alu_valid),
    .i_alu_z(alu_z), .i_alu_g(alu_g), .i_alu_l(alu_l)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [4:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      5'd1:    return a + b;
      5'd3:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  // Registered ALU: result and valid one cycle after the enable pulse.
  always @(posedge clk) begin
    if (rst) begin
      alu_valid <= 1'b0;
      alu_data  <= '0;
      alu_z     <= 1'b0;
      alu_g     <= 1'b0;
      alu_l     <= 1'b0;
    end else begin
      alu_valid <= alu_en && !stall;
      if (alu_en) begin
        alu_data <= alu_fn(alu_op, alu_a, alu_b);
        alu_z    <= (alu_fn(alu_op, alu_a, alu_b) == '0);
        alu_g    <= (alu_a > alu_b);
        alu_l    <= (alu_a < alu_b);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [4:0] op);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_op[i*5 +: 5]        = op;
  endtask

  task automatic wait_rsp(input string tag);
    int cyc;
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    if (!rsp_valid) check({tag, "_rsp_timeout"}, 64'd0, 64'd1);
  endtask

  function automatic int exp_rr_id(input int n);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 0;
`else
    return n % NREQ;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng, nr, last, n;
    logic [NREQ-1:0] exp_oh;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    rsp_ready = 1'b0; stall = 1'b0;
    tick(); tick();
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_alu_en", alu_en, 1'b0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    rst = 1'b0;

    // 1. Single request
    set_req(0, 32'd5, 32'd7, 5'b00001);
    req_valid = 4'b0001;
    #1;
    check("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    check("t1_alu_en", alu_en, 1'b1);
    check("t1_alu_ops", {alu_a, alu_b, alu_op}, {32'd5, 32'd7, 5'd1});
    tick();
    check("t1_alu_en_pulse", alu_en, 1'b0);
    check("t1_no_rsp_yet", rsp_valid, 1'b0);
    tick();
    check("t1_rsp_valid", rsp_valid, 1'b1);
    check("t1_rsp", {rsp_id, rsp_data, rsp_err}, {2'd0, 32'd12, 1'b0});
    check("t1_flags", rsp_flags, 3'b001);
    rsp_ready = 1'b1;
    tick();
    check("t1_rsp_done", rsp_valid, 1'b0);

    // 2. Round-robin with all four valid
    for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(10 + i), WIDTH'(i), 5'b00001);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    do_reset();
    #1;
    ng = 0; nr = 0; last = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (req_ready != '0 && ng < 5) begin
        exp_oh = 4'b0001 << exp_rr_id(ng);
        check($sformatf("t2_grant%0d", ng), req_ready, exp_oh);
        if (ng > 0) check("t2_grant_gap", cyc - last, 64'd4);
        last = cyc;
        ng++;
      end
      if (rsp_valid && nr < 5) begin
        check($sformatf("t2_rsp_id%0d", nr), rsp_id, exp_rr_id(nr));
        check($sformatf("t2_rsp_data%0d", nr), rsp_data, 10 + 2 * exp_rr_id(nr));
        nr++;
      end
      tick();
    end
    check("t2_num_grants", ng, 64'd5);

    // 3. Backpressure
    rsp_ready = 1'b0;
    do_reset();
    wait_rsp("t3");
    check("t3_rsp", {rsp_id, rsp_data}, {2'd0, 32'd10});
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_hold", {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'd0, 32'd10});
      check("t3_no_ready", req_ready, 4'b0000);
      check("t3_no_alu_en", alu_en, 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    check("t3_accepted", rsp_valid, 1'b0);
`ifdef ALU_ARB_FIXED_PRIO_EN
    check("t3_next_grant", req_ready, 4'b0001);
`else
    check("t3_next_grant", req_ready, 4'b0010);
`endif

    // 4. Timeout
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    do_reset();
    stall = 1'b1;
    set_req(0, 32'd9, 32'd9, 5'b00001);
    req_valid = 4'b0001;
    #1;
    check("t4_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    tick();
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check("t4_wait_cycles", n, 64'd15);
    check("t4_err", {rsp_err, rsp_data, rsp_flags}, {1'b1, 32'd0, 3'd0});
    rsp_ready = 1'b1;
    tick();
    stall = 1'b0;

    // 5. Reset while in WAIT
    for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(10 + i), WIDTH'(i), 5'b00001);
    req_valid = 4'b1111;
    do_reset();
    #1;
    check("t5_first_grant", req_ready, 4'b0001);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t5_zero_rsp", {rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err}, 64'd0);
    check("t5_zero_alu", {alu_en, alu_a, alu_op}, 64'd0);
    check("t5_zero_ready", req_ready, 4'b0000);
    rst = 1'b0;
    #1;
    check("t5_regrant", req_ready, 4'b0001);

    // 6. Flags on subtract-to-zero
    req_valid = 4'b0000;
    do_reset();
    set_req(0, 32'd3, 32'd3, 5'b00011);
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = 4'b0000;
    wait_rsp("t6");
    check("t6_flags", rsp_flags, 3'b100);
    check("t6_rsp", {rsp_data, rsp_err}, {32'd0, 1'b0});
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
